// File: rtl/shift_register_ctl_if.sv
// Handshake/data bundle for shift_register_ctl.
// Optional parity output is present only when SHIFT_REG_PARITY_EN is defined.
interface shift_register_ctl_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
);
  logic                 clear;
  logic                 enable;
  logic                 start;
  logic [2:0]           mode;
  logic [CNT_WIDTH-1:0] shift_amt;
  logic [WIDTH-1:0]     d;
  logic                 serial_in;
  logic [WIDTH-1:0]     q;
  logic                 serial_out;
  logic                 busy;
  logic                 done;
`ifdef SHIFT_REG_PARITY_EN
  logic                 parity;
`endif

  modport master (
    output clear, enable, start, mode, shift_amt, d, serial_in,
`ifdef SHIFT_REG_PARITY_EN
    input  parity,
`endif
    input  q, serial_out, busy, done
  );

  modport slave (
    input  clear, enable, start, mode, shift_amt, d, serial_in,
`ifdef SHIFT_REG_PARITY_EN
    output parity,
`endif
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_register_ctl.sv
// Universal shift register with single-step path and N-step start/busy/done sequencer.
// Define SHIFT_REG_PARITY_EN to add a combinational parity output of q.
module shift_register_ctl #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  shift_register_ctl_if.slave bus
);
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_SRA  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     q, q_n;
  logic                 so, so_n;
  logic                 busy, busy_n;
  logic                 done, done_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           lmode, lmode_n;

  logic [2:0]           smode;
  logic [WIDTH-1:0]     sq;
  logic                 sbit;

  function automatic logic is_shift(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ROR);
  endfunction

  // One step of the selected mode; the sequencer uses the latched mode so
  // bus.mode may change freely while busy.
  always_comb begin
    smode = (state == SHIFT) ? lmode : bus.mode;
    sq    = q;
    sbit  = so;
    case (smode)
      M_LOAD: sq = bus.d;
      M_SHL: begin sq = {q[WIDTH-2:0], bus.serial_in}; sbit = q[WIDTH-1]; end
      M_SHR: begin sq = {bus.serial_in, q[WIDTH-1:1]}; sbit = q[0];       end
      M_SRA: begin sq = {q[WIDTH-1], q[WIDTH-1:1]};    sbit = q[0];       end
      M_ROL: begin sq = {q[WIDTH-2:0], q[WIDTH-1]};    sbit = q[WIDTH-1]; end
      M_ROR: begin sq = {q[0], q[WIDTH-1:1]};          sbit = q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    so_n    = so;
    busy_n  = busy;
    done_n  = 1'b0;
    cnt_n   = cnt;
    lmode_n = lmode;
    if (bus.clear) begin
      state_n = IDLE;
      q_n     = '0;
      so_n    = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_shift(bus.mode) && (bus.shift_amt != '0)) begin
              lmode_n = bus.mode;
              cnt_n   = bus.shift_amt;
              busy_n  = 1'b1;
              state_n = SHIFT;
            end else begin
              // zero-length or non-shift start: only load has an effect
              if (bus.mode == M_LOAD) q_n = bus.d;
              done_n = 1'b1;
            end
          end else if (bus.enable) begin
            q_n  = sq;
            so_n = sbit;
          end
        end
        SHIFT: begin
          q_n   = sq;
          so_n  = sbit;
          cnt_n = cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      so    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      lmode <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
      so    <= so_n;
      busy  <= busy_n;
      done  <= done_n;
      cnt   <= cnt_n;
      lmode <= lmode_n;
    end
  end

  assign bus.q          = q;
  assign bus.serial_out = so;
  assign bus.busy       = busy;
  assign bus.done       = done;
`ifdef SHIFT_REG_PARITY_EN
  assign bus.parity     = ^q;
`endif
endmodule

// File: doc/shift_register_ctl.md
Name: shift_register_ctl

Overview:
Parametrised universal shift register with load, hold, logical, arithmetic and rotate modes. It has a multi-cycle shift sequencer with a start/busy/done handshake. It is the next-generation datapath register for the sequential multiplier, holding partial products and multiplier operands that need shifting by N positions per step. A single-step enable path remains for plain register use.

Parameters:
WIDTH, 8, data width in bits (>=2)
CNT_WIDTH, 4, width of shift-amount field and internal down-counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
clear  input  1  synchronous clear of q and sequencer
enable  input  1  single-step operation strobe (idle only)
start  input  1  launch multi-cycle operation (idle only)
mode  input  3  operation select (see Behaviour)
shift_amt  input  CNT_WIDTH  number of shift steps for start
d  input  WIDTH  parallel load data
serial_in  input  1  fill bit for logical shifts
q  output  WIDTH  register contents
serial_out  output  1  last bit shifted out
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): q=0, serial_out=0, busy=0, done=0, counter=0, state IDLE. Reset mid-operation aborts with no done pulse.
- Mode encoding, one step:
  - 000: hold
  - 001: load q<=d
  - 010: SHL, q<={q[W-2:0],serial_in}, out=q[W-1]
  - 011: SHR, q<={serial_in,q[W-1:1]}, out=q[0]
  - 100: SRA, MSB replicated, out=q[0]
  - 101: ROL, out=q[W-1]
  - 110: ROR, out=q[0]
  - 111: reserved, acts as hold
- serial_out updates only on shift steps. It holds otherwise, and is not changed by load.
- Priority per edge: reset > clear > start (IDLE) > enable (IDLE).
- clear: q<=0, serial_out<=0, busy<=0, done<=0, state<=IDLE. Applies in any state; an aborted operation gives no done.
- Single step: in IDLE with enable=1 and start=0, perform one mode step at the edge. done is not asserted.
- States: IDLE, SHIFT.
- start in IDLE with a shift mode (010-110) and shift_amt=N>0:
  - At the start edge, latch mode, load counter=N, busy<=1, state SHIFT. q is unchanged at this edge.
  - At each of the next N edges, perform one step with the latched mode and decrement the counter.
  - At the Nth step edge: busy<=0, done<=1, state IDLE.
  - done clears at the following edge.
  - Latency from the start edge to done high: N+1 edges.
- start in IDLE with shift_amt=0, or with a non-shift mode (000/001/111):
  - The mode's step executes at the start edge (load loads d; others hold). busy stays 0.
  - done<=1 at that edge, for one cycle.
- While busy: start, enable, mode, shift_amt and d are ignored. serial_in is sampled live each step.
- N > WIDTH is legal:
  - Rotates wrap (ROL by W+k equals ROL by k).
  - SHL/SHR fill entirely with serial_in.
  - SRA saturates to all-sign.
- done and start in the same cycle: the new start is accepted, since done only occurs in IDLE. Back-to-back operations are allowed.
- All outputs are registered, except parity (optional feature).

Optional Feature:
SHIFT_REG_PARITY_EN:
- Defined: adds output port parity (1 bit) = XOR reduction of q, combinational from q. It is 0 after reset.
- Undefined: parity port and logic are absent. All other behaviour is identical.

Test Plan:
1. Load d=0xA5 with mode=001, enable=1, then assert reset asynchronously mid-cycle -> q=0x00, busy=0, done=0, serial_out=0 immediately, before the next clock edge.
2. Load d=0x96 (mode=001, enable=1) -> q=0x96. Then enable=0, d=0x00 for 3 cycles -> q stays 0x96.
3. q=0x96, start with mode=100 (SRA), shift_amt=3 -> busy high for 3 cycles. q steps through 0xCB, 0xE5, 0xF2. serial_out=1 at the end. done is high for exactly one cycle, 4 edges after start.
4. q=0x81, start with mode=101 (ROL), shift_amt=9 -> after 9 steps q=0x03, done pulses once. Then start with shift_amt=0 -> done the next edge, busy never high, q=0x03.
5. q=0x40, single-step SHL with serial_in=1, twice -> q=0x81 with serial_out=0, then q=0x03 with serial_out=1. busy=0 and done=0 throughout.
6. q=0xF0, start with mode=110 (ROR), shift_amt=5, assert clear on the 2nd busy cycle -> q=0x00, busy=0, no done pulse. A start pulse during busy (before clear) is ignored.
